switch_port_arbiter: RTL and testbench
======================================

# switch_port_arbiter

Shares one registered-readdata switch PIO slave (2-bit address, 32-bit readdata, fixed one-cycle read latency, no waitrequest) among NUM_MASTERS Nios II data masters in the multicore system. Each master gets an Avalon-MM read interface with waitrequest. The block arbitrates round-robin, drives the slave address, and signals completion to the winner only when the slave's readdata is valid. Writes are accepted and discarded.

## Interface
- NUM_MASTERS, 4: number of requesting masters, 2..8.
- ADDR_W, 2: slave word-address width.
- DATA_W, 32: readdata width.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_read  in  NUM_MASTERS  per-master read request, held until accepted.
- m_write  in  NUM_MASTERS  per-master write strobe; ignored functionally.
- m_address  in  NUM_MASTERS*ADDR_W  per-master address; master i uses bits [i*ADDR_W +: ADDR_W].
- m_waitrequest  out  NUM_MASTERS  per-master stall.
- m_readdata  out  DATA_W  shared readdata bus to all masters; a master samples it only in its completion cycle.
- s_address  out  ADDR_W  registered address to the switch PIO.
- s_readdata  in  DATA_W  switch PIO readdata; valid one clock after s_address changes.
- grant  out  NUM_MASTERS  registered one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, WAIT and DONE.
- IDLE:
  - If any m_read bit is set, pick the winner by round-robin: the first set bit searching from last_grant+1 upward, with wrap-around.
  - Register grant to the one-hot winner.
  - Register s_address from the winner's m_address.
  - Set last_grant to the winner and go to WAIT.
  - Otherwise stay in IDLE; grant = 0.
- WAIT: unconditional transition to DONE. The slave registers readdata from s_address at the edge that ends WAIT.
- DONE: completion cycle for the granted master. Next state is IDLE; grant clears on exit.
- m_readdata = s_readdata, combinational pass-through.
- m_waitrequest[i] = m_read[i] AND NOT (state == DONE AND grant[i]).
  - Writes never stall.
  - Idle masters see waitrequest low.
- The address is sampled only in IDLE. Later changes to m_address are ignored for that transaction.
- If a master drops m_read before DONE (Avalon protocol violation), the transaction still runs to DONE and the data is discarded. No lock-up occurs and there is no error flag.
- A master that keeps m_read high after its DONE cycle starts a new transaction. It competes normally and is lowest priority because it was the last grant.

## Timing
- Reset values:
  - state = IDLE
  - grant = 0
  - s_address = 0
  - busy = 0
  - last_grant = NUM_MASTERS-1, so master 0 wins first after reset
- m_waitrequest and m_readdata are combinational, with no reset value of their own. m_waitrequest = m_read during reset.
- Read latency, with the request first seen in IDLE at cycle 0:
  - s_address is valid from cycle 1.
  - Completion (waitrequest low) is in cycle 2.
  - The arbiter is back in IDLE in cycle 3.
- Throughput is one read per 3 cycles. Back-to-back requests see no idle bubble beyond IDLE itself.
- Reset asserted mid-transaction forces IDLE immediately. The in-flight read is never completed, so that master keeps waitrequest high and is re-arbitrated after reset.
- Simultaneous requests from all masters are served in order last_grant+1, +2, … and wrap. With N masters continuously requesting, each waits at most 3*(N-1) cycles beyond its own service time.
- A read and a write from different masters in the same cycle: the write completes in that cycle and the read proceeds normally.

## Test plan
- Single read: switches = 3'b101, master 1 reads address 0 at cycle 0 -> s_address = 0 at cycle 1; m_waitrequest[1] low with m_readdata = 32'h5 at cycle 2; busy low at cycle 3.
- Four-way contention after reset: all m_read high at cycle 0 -> completions at cycles 2, 5, 8, 11 for masters 0, 1, 2, 3; grant is one-hot throughout.
- Fairness: master 0 and master 2 hold m_read continuously for 12 cycles -> grants alternate 0, 2, 0, 2; neither master is served twice in a row.
- Address decode: master 3 reads address 2 with switches = 3'b111 -> completion returns 32'h0. A switch change during WAIT is visible only if it occurs before the slave's sampling edge.
- Reset mid-read: reset pulsed during WAIT for master 1 -> grant = 0, busy = 0, s_address = 0 asynchronously. After release, master 1 (still requesting) completes 3 cycles later.
- Write discard: master 2 asserts m_write to address 0 while master 0's read is in WAIT -> m_waitrequest[2] low the same cycle; master 0's completion is unaffected, with the same cycle and data.

Source files
------------

// File: rtl/switch_port_arbiter.sv
// Round-robin arbiter sharing one registered-readdata switch PIO slave among
// several Avalon-MM read masters; writes are accepted without stalling and discarded.
module switch_port_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [ADDR_W-1:0]             s_address,
  input  logic [DATA_W-1:0]             s_readdata,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int unsigned NM    = NUM_MASTERS;
  localparam int          IDX_W = $clog2(NUM_MASTERS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             unused_write;

  assign unused_write = ^m_write;

  // First requester strictly after last_grant, wrapping; last_grant itself is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      idx = IDX_W'((32'(last_grant) + k) % NM);
      if (!found && m_read[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      s_address  <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= NUM_MASTERS'(1) << winner;
            s_address  <= m_address[winner*ADDR_W +: ADDR_W];
            last_grant <= winner;
            state      <= WAIT;
          end else begin
            grant <= '0;
          end
        end
        WAIT: state <= DONE;
        DONE: begin
          state <= IDLE;
          grant <= '0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign m_readdata    = s_readdata;
  assign m_waitrequest = m_read & ~((state == DONE) ? grant : '0);

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed self-checking bench for switch_port_arbiter with a behavioural
// switch PIO (3 switches at address 0, registered one-cycle readdata).
module tb_switch_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  m_read;
  logic [3:0]  m_write;
  logic [7:0]  m_address;
  logic [3:0]  m_waitrequest;
  logic [31:0] m_readdata;
  logic [1:0]  s_address;
  logic [31:0] s_readdata = '0;
  logic [3:0]  grant;
  logic        busy;
  logic [2:0]  switches;

  int pass_cnt  = 0;
  int total_cnt = 0;

  switch_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .s_address(s_address), .s_readdata(s_readdata), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    s_readdata <= (s_address == 2'd0) ? {29'd0, switches} : 32'd0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; m_read = '0; m_write = '0; m_address = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; m_read = 4'b1010; m_write = '0; m_address = 8'hFF; switches = 3'b000;
    #1;
    total_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    total_cnt++; if (s_address !== 2'd0) $display("FAIL reset_s_address: got %0d expected %0d", s_address, 0); else pass_cnt++;
    total_cnt++; if (m_waitrequest !== 4'b1010) $display("FAIL reset_waitrequest: got %b expected %b", m_waitrequest, 4'b1010); else pass_cnt++;
    tick;
    total_cnt++; if (grant !== 4'b0000) $display("FAIL reset_hold_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    m_read = '0;
  endtask

  task automatic test_single_read;
    do_reset;
    switches = 3'b101; m_read = 4'b0010; m_address = 8'h00;
    #1;
    total_cnt++; if (m_waitrequest !== 4'b0010) $display("FAIL single_c0_wait: got %b expected %b", m_waitrequest, 4'b0010); else pass_cnt++;
    tick;
    total_cnt++; if (s_address !== 2'd0) $display("FAIL single_c1_addr: got %0d expected %0d", s_address, 0); else pass_cnt++;
    total_cnt++; if (grant !== 4'b0010) $display("FAIL single_c1_grant: got %b expected %b", grant, 4'b0010); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_c1_busy: got %b expected %b", busy, 1'b1); else pass_cnt++;
    total_cnt++; if (m_waitrequest !== 4'b0010) $display("FAIL single_c1_wait: got %b expected %b", m_waitrequest, 4'b0010); else pass_cnt++;
    tick;
    total_cnt++; if (m_waitrequest !== 4'b0000) $display("FAIL single_c2_wait: got %b expected %b", m_waitrequest, 4'b0000); else pass_cnt++;
    total_cnt++; if (m_readdata !== 32'h5) $display("FAIL single_c2_data: got %h expected %h", m_readdata, 32'h5); else pass_cnt++;
    m_read = '0;
    tick;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_c3_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    total_cnt++; if (grant !== 4'b0000) $display("FAIL single_c3_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
  endtask

  task automatic test_contention;
    logic [3:0] rd;
    logic [3:0] eg;
    logic [3:0] ew;
    do_reset;
    switches = 3'b011; rd = 4'b1111; m_read = rd; m_address = 8'h00;
    for (int c = 0; c < 12; c++) begin
      #1;
      eg = (c % 3 == 0) ? 4'b0000 : 4'(1 << (c / 3));
      ew = rd & ~((c % 3 == 2) ? eg : 4'b0000);
      total_cnt++; if (grant !== eg) $display("FAIL contention_grant c%0d: got %b expected %b", c, grant, eg); else pass_cnt++;
      total_cnt++; if (m_waitrequest !== ew) $display("FAIL contention_wait c%0d: got %b expected %b", c, m_waitrequest, ew); else pass_cnt++;
      total_cnt++; if (!$onehot0(grant)) $display("FAIL contention_onehot c%0d: got %b expected one-hot or zero", c, grant); else pass_cnt++;
      if (c % 3 == 2) begin
        total_cnt++; if (m_readdata !== 32'h3) $display("FAIL contention_data c%0d: got %h expected %h", c, m_readdata, 32'h3); else pass_cnt++;
        rd = rd & ~eg;
        m_read = rd;
      end
      tick;
    end
  endtask

  task automatic test_fairness;
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b0001; seq[3] = 4'b0100;
    do_reset;
    m_read = 4'b0101; m_address = 8'h00;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 1) begin
        total_cnt++; if (grant !== seq[c / 3]) $display("FAIL fair_grant c%0d: got %b expected %b", c, grant, seq[c / 3]); else pass_cnt++;
      end
      if (c % 3 == 2) begin
        total_cnt++; if (m_waitrequest !== (4'b0101 & ~seq[c / 3])) $display("FAIL fair_wait c%0d: got %b expected %b", c, m_waitrequest, 4'b0101 & ~seq[c / 3]); else pass_cnt++;
      end
      tick;
    end
    m_read = '0;
    tick;
    total_cnt++; if (busy !== 1'b0) $display("FAIL fair_idle: got %b expected %b", busy, 1'b0); else pass_cnt++;
  endtask

  task automatic test_address_decode;
    do_reset;
    switches = 3'b111; m_read = 4'b1000; m_address = {2'd2, 6'd0};
    tick;
    total_cnt++; if (s_address !== 2'd2) $display("FAIL addr_c1_saddr: got %0d expected %0d", s_address, 2); else pass_cnt++;
    m_address = 8'h00;
    tick;
    total_cnt++; if (m_waitrequest !== 4'b0000) $display("FAIL addr_c2_wait: got %b expected %b", m_waitrequest, 4'b0000); else pass_cnt++;
    total_cnt++; if (m_readdata !== 32'h0) $display("FAIL addr_c2_data: got %h expected %h", m_readdata, 32'h0); else pass_cnt++;
    total_cnt++; if (s_address !== 2'd2) $display("FAIL addr_c2_saddr_held: got %0d expected %0d", s_address, 2); else pass_cnt++;
    m_read = '0;
    tick;
    // switch change inside WAIT lands before the slave sampling edge
    m_read = 4'b1000; m_address = 8'h00;
    tick;
    switches = 3'b010;
    tick;
    total_cnt++; if (m_readdata !== 32'h2) $display("FAIL addr_late_switch: got %h expected %h", m_readdata, 32'h2); else pass_cnt++;
    switches = 3'b111;
    #1;
    total_cnt++; if (m_readdata !== 32'h2) $display("FAIL addr_after_sample: got %h expected %h", m_readdata, 32'h2); else pass_cnt++;
    m_read = '0;
    tick;
  endtask

  task automatic test_reset_mid_read;
    do_reset;
    switches = 3'b101; m_read = 4'b0010; m_address = {4'd0, 2'd3, 2'd0};
    tick;
    total_cnt++; if (s_address !== 2'd3) $display("FAIL rstmid_c1_saddr: got %0d expected %0d", s_address, 3); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (grant !== 4'b0000) $display("FAIL rstmid_grant: got %b expected %b", grant, 4'b0000); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
    total_cnt++; if (s_address !== 2'd0) $display("FAIL rstmid_saddr: got %0d expected %0d", s_address, 0); else pass_cnt++;
    total_cnt++; if (m_waitrequest !== 4'b0010) $display("FAIL rstmid_wait: got %b expected %b", m_waitrequest, 4'b0010); else pass_cnt++;
    tick;
    reset = 1'b0;
    #1;
    total_cnt++; if (m_waitrequest !== 4'b0010) $display("FAIL rstmid_r0_wait: got %b expected %b", m_waitrequest, 4'b0010); else pass_cnt++;
    tick;
    total_cnt++; if (grant !== 4'b0010) $display("FAIL rstmid_r1_grant: got %b expected %b", grant, 4'b0010); else pass_cnt++;
    tick;
    total_cnt++; if (m_waitrequest !== 4'b0000) $display("FAIL rstmid_r2_wait: got %b expected %b", m_waitrequest, 4'b0000); else pass_cnt++;
    m_read = '0;
    tick;
  endtask

  task automatic test_write_discard;
    do_reset;
    switches = 3'b101; m_read = 4'b0001; m_address = 8'h00;
    tick;
    m_write = 4'b0100;
    #1;
    total_cnt++; if (m_waitrequest !== 4'b0001) $display("FAIL write_c1_wait: got %b expected %b", m_waitrequest, 4'b0001); else pass_cnt++;
    tick;
    total_cnt++; if (m_waitrequest !== 4'b0000) $display("FAIL write_c2_wait: got %b expected %b", m_waitrequest, 4'b0000); else pass_cnt++;
    total_cnt++; if (grant !== 4'b0001) $display("FAIL write_c2_grant: got %b expected %b", grant, 4'b0001); else pass_cnt++;
    total_cnt++; if (m_readdata !== 32'h5) $display("FAIL write_c2_data: got %h expected %h", m_readdata, 32'h5); else pass_cnt++;
    m_write = '0; m_read = '0;
    tick;
    total_cnt++; if (busy !== 1'b0) $display("FAIL write_c3_busy: got %b expected %b", busy, 1'b0); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_fairness;
    test_address_decode;
    test_reset_mid_read;
    test_write_discard;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
